// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the control FSM:
// FSM state encoding, ARM-ordered condition codes and NZCV bit positions.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_LOAD_REG = 2'd2,
    ST_ALU      = 2'd3
  } fsm_state_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Flags are packed as {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/fetch_unit_cond_eval.sv
// Combinational condition evaluator: decides whether an instruction with
// the given 4-bit condition field executes under the current NZCV flags.
module cond_eval
  import fetch_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic flagN;
  logic flagZ;
  logic flagC;
  logic flagV;

  assign flagN = flags[FLAG_N];
  assign flagZ = flags[FLAG_Z];
  assign flagC = flags[FLAG_C];
  assign flagV = flags[FLAG_V];

  // Map each condition code onto its flag expression
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = flagZ;
      COND_NE: pass = !flagZ;
      COND_CS: pass = flagC;
      COND_CC: pass = !flagC;
      COND_MI: pass = flagN;
      COND_PL: pass = !flagN;
      COND_VS: pass = flagV;
      COND_VC: pass = !flagV;
      COND_HI: pass = flagC && !flagZ;
      COND_LS: pass = !flagC || flagZ;
      COND_GE: pass = (flagN == flagV);
      COND_LT: pass = (flagN != flagV);
      COND_GT: pass = !flagZ && (flagN == flagV);
      COND_LE: pass = flagZ || (flagN != flagV);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and condition evaluation stage beside the control FSM.
// Holds the PC, drives the synchronous program RAM, latches the fetched
// word and produces condition_code_check during LOAD_REG.
// Build option: define COND_EXEC_EN to enable the NZCV flags register and
// real condition evaluation; without it every instruction executes and
// flags reads as zero.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        curr_state,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              flags_we,
  input  logic [3:0]        flags_in,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              condition_code_check,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags
);

  fsm_state_e state;
  logic isFetch;
  logic isLoadReg;
  logic isAlu;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] instr_d;
  logic              instrValid_q;
  logic              instrValid_d;
  logic [3:0]        flags_q;
  logic              evalPass;

  assign state     = fsm_state_e'(curr_state);
  assign isFetch   = (state == ST_FETCH);
  assign isLoadReg = (state == ST_LOAD_REG);
  assign isAlu     = (state == ST_ALU);

  // The RAM is addressed straight from the PC; the read is only enabled in FETCH
  assign ram_en   = isFetch;
  assign ram_addr = pc_q;

  // Condition field lives in the top nibble of the word coming back from RAM
  cond_eval u_condEval (
    .cond  (ram_rdata[DATA_W-1 -: 4]),
    .flags (flags_q),
    .pass  (evalPass)
  );

`ifdef COND_EXEC_EN
  // Flags register: written by the ALU only while the FSM is in ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (isAlu && flags_we) begin
      flags_q <= flags_in;
    end
  end

  // Reset gates the check so it drops immediately, even mid-LOAD_REG
  assign condition_code_check = rst_n && isLoadReg && evalPass;
`else
  logic unused_condInputs;

  assign flags_q              = 4'b0000;
  assign condition_code_check = rst_n && isLoadReg;
  assign unused_condInputs    = ^{flags_we, flags_in, evalPass};
`endif

  // Next PC: increment after each fetch, branch target only when the ALU says so
  always_comb begin
    pc_d = pc_q;
    if (isFetch) begin
      pc_d = pc_q + ADDR_W'(1);
    end else if (isAlu && pc_load) begin
      pc_d = pc_target;
    end
  end

  // Instruction latch captures the RAM word at the end of LOAD_REG regardless of the condition
  always_comb begin
    instr_d      = instr_q;
    instrValid_d = isLoadReg;
    if (isLoadReg) begin
      instr_d = ram_rdata;
    end
  end

  // State registers for PC, latched instruction and its valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= '0;
      instr_q      <= '0;
      instrValid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instrValid_q <= instrValid_d;
    end
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instrValid_q;
  assign flags       = flags_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized state/branch/flag sequence compared against a cycle-level
// reference model of the fetch stage.
module tb_fetch_unit;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_ALU = 2'd3;

`ifdef COND_EXEC_EN
  localparam bit CondEn = 1'b1;
`else
  localparam bit CondEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        curr_state;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic              flags_we;
  logic [3:0]        flags_in;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              condition_code_check;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        flags;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int failures = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .curr_state           (curr_state),
    .pc_load              (pc_load),
    .pc_target            (pc_target),
    .flags_we             (flags_we),
    .flags_in             (flags_in),
    .ram_en               (ram_en),
    .ram_addr             (ram_addr),
    .ram_rdata            (ram_rdata),
    .instr                (instr),
    .instr_valid          (instr_valid),
    .condition_code_check (condition_code_check),
    .pc                   (pc),
    .flags                (flags)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Synchronous program RAM, one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) ram_rdata <= mem[ram_addr];
  end

  // Reference condition rule: flags packed {N,Z,C,V}
  function automatic logic condModel(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (!CondEn) return 1'b1;
    case (code)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle's inputs shortly after the rising edge and let them settle
  task automatic applyStimulus(input logic [1:0] st, input logic pl, input logic [ADDR_W-1:0] tgt,
                               input logic fwe, input logic [3:0] fin);
    curr_state = st;
    pc_load    = pl;
    pc_target  = tgt;
    flags_we   = fwe;
    flags_in   = fin;
    #1;
  endtask

  // Advance past the next rising edge so registered outputs can be sampled
  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(S_LOAD, 1'b0, '0, 1'b0, 4'h0);
    checks++; if (pc !== 8'h00) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc, 8'h00); end
    checks++; if (instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=%h", instr, 32'h0); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (flags !== 4'h0) begin failures++; $display("[TB] FAIL reset_flags got=%h exp=0", flags); end
    checks++; if (condition_code_check !== 1'b0) begin failures++; $display("[TB] FAIL reset_ccc got=%b exp=0", condition_code_check); end
    applyStimulus(S_IDLE, 1'b0, '0, 1'b0, 4'h0);
    checks++; if (ram_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_ram_en got=%b exp=0", ram_en); end
    clockEdge();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(S_IDLE, 1'b0, '0, 1'b0, 4'h0);
      checks++; if (ram_en !== 1'b0) begin failures++; $display("[TB] FAIL idle_ram_en got=%b exp=0", ram_en); end
      clockEdge();
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_valid got=%b exp=0", instr_valid); end
      checks++; if (pc !== 8'h00) begin failures++; $display("[TB] FAIL idle_pc got=%h exp=00", pc); end
    end
  endtask

  task automatic test_two_fetches();
    mem[0] = 32'hE000_0001;
    mem[1] = 32'h0000_0002;
    applyStimulus(S_FETCH, 1'b0, '0, 1'b0, 4'h0);
    checks++; if (ram_en !== 1'b1 || ram_addr !== 8'h00) begin failures++; $display("[TB] FAIL fetch0_addr got en=%b addr=%h exp en=1 addr=00", ram_en, ram_addr); end
    checks++; if (condition_code_check !== 1'b0) begin failures++; $display("[TB] FAIL fetch0_ccc got=%b exp=0", condition_code_check); end
    clockEdge();
    applyStimulus(S_LOAD, 1'b0, '0, 1'b0, 4'h0);
    checks++; if (condition_code_check !== 1'b1) begin failures++; $display("[TB] FAIL load0_ccc_al got=%b exp=1", condition_code_check); end
    clockEdge();
    checks++; if (instr !== 32'hE000_0001 || instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL load0_instr got=%h v=%b exp=e0000001 v=1", instr, instr_valid); end
    applyStimulus(S_FETCH, 1'b0, '0, 1'b0, 4'h0);
    checks++; if (ram_addr !== 8'h01) begin failures++; $display("[TB] FAIL fetch1_addr got=%h exp=01", ram_addr); end
    clockEdge();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL valid_one_cycle got=%b exp=0", instr_valid); end
    applyStimulus(S_LOAD, 1'b0, '0, 1'b0, 4'h0);
    checks++; if (condition_code_check !== !CondEn) begin failures++; $display("[TB] FAIL load1_ccc_eq got=%b exp=%b", condition_code_check, !CondEn); end
    clockEdge();
    checks++; if (instr !== 32'h0000_0002 || instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL load1_instr got=%h v=%b exp=00000002 v=1", instr, instr_valid); end
  endtask

  task automatic test_flags();
    logic [3:0] expF;
    expF = CondEn ? 4'b0100 : 4'b0000;
    mem[2] = 32'h0000_00AB;
    mem[3] = 32'h0000_0CD0;
    applyStimulus(S_ALU, 1'b0, '0, 1'b1, 4'b0100);
    clockEdge();
    checks++; if (flags !== expF) begin failures++; $display("[TB] FAIL flags_write got=%h exp=%h", flags, expF); end
    applyStimulus(S_FETCH, 1'b0, '0, 1'b0, 4'h0);
    clockEdge();
    applyStimulus(S_LOAD, 1'b0, '0, 1'b0, 4'h0);
    checks++; if (condition_code_check !== 1'b1) begin failures++; $display("[TB] FAIL flags_eq_pass got=%b exp=1", condition_code_check); end
    clockEdge();
    applyStimulus(S_FETCH, 1'b0, '0, 1'b1, 4'b0000);
    clockEdge();
    checks++; if (flags !== expF) begin failures++; $display("[TB] FAIL flags_we_in_fetch got=%h exp=%h", flags, expF); end
    applyStimulus(S_LOAD, 1'b0, '0, 1'b1, 4'b0000);
    checks++; if (condition_code_check !== 1'b1) begin failures++; $display("[TB] FAIL flags_eq_hold got=%b exp=1", condition_code_check); end
    clockEdge();
    applyStimulus(S_ALU, 1'b0, '0, 1'b1, 4'b0000);
    clockEdge();
    checks++; if (flags !== 4'b0000) begin failures++; $display("[TB] FAIL flags_clear got=%h exp=0", flags); end
  endtask

  task automatic test_branch();
    applyStimulus(S_ALU, 1'b1, 8'h40, 1'b0, 4'h0);
    clockEdge();
    applyStimulus(S_FETCH, 1'b0, 8'h00, 1'b0, 4'h0);
    checks++; if (ram_addr !== 8'h40) begin failures++; $display("[TB] FAIL branch_addr got=%h exp=40", ram_addr); end
    clockEdge();
    applyStimulus(S_LOAD, 1'b1, 8'h10, 1'b0, 4'h0);
    clockEdge();
    checks++; if (pc !== 8'h41) begin failures++; $display("[TB] FAIL branch_ignored_load got=%h exp=41", pc); end
    applyStimulus(S_ALU, 1'b1, 8'hFF, 1'b0, 4'h0);
    clockEdge();
    applyStimulus(S_FETCH, 1'b0, 8'h00, 1'b0, 4'h0);
    checks++; if (ram_addr !== 8'hFF) begin failures++; $display("[TB] FAIL wrap_addr got=%h exp=ff", ram_addr); end
    clockEdge();
    checks++; if (pc !== 8'h00) begin failures++; $display("[TB] FAIL pc_wrap got=%h exp=00", pc); end
  endtask

  task automatic test_nv();
    mem[8'h20] = 32'hF000_0000;
    applyStimulus(S_ALU, 1'b1, 8'h20, 1'b0, 4'h0);
    clockEdge();
    applyStimulus(S_FETCH, 1'b0, 8'h00, 1'b0, 4'h0);
    clockEdge();
    applyStimulus(S_LOAD, 1'b0, 8'h00, 1'b0, 4'h0);
    checks++; if (condition_code_check !== !CondEn) begin failures++; $display("[TB] FAIL nv_ccc got=%b exp=%b", condition_code_check, !CondEn); end
    clockEdge();
    checks++; if (instr !== 32'hF000_0000) begin failures++; $display("[TB] FAIL nv_instr got=%h exp=f0000000", instr); end
  endtask

  task automatic test_reset_mid();
    mem[8'h12] = 32'hE000_1234;
    applyStimulus(S_ALU, 1'b1, 8'h12, 1'b0, 4'h0);
    clockEdge();
    applyStimulus(S_FETCH, 1'b0, 8'h00, 1'b0, 4'h0);
    clockEdge();
    applyStimulus(S_LOAD, 1'b0, 8'h00, 1'b0, 4'h0);
    checks++; if (condition_code_check !== 1'b1 || pc !== 8'h13) begin failures++; $display("[TB] FAIL mid_pre got ccc=%b pc=%h exp ccc=1 pc=13", condition_code_check, pc); end
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 8'h00) begin failures++; $display("[TB] FAIL mid_reset_pc got=%h exp=00", pc); end
    checks++; if (condition_code_check !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_ccc got=%b exp=0", condition_code_check); end
    clockEdge();
    checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_instr got=%h v=%b exp=0 v=0", instr, instr_valid); end
    rst_n = 1'b1;
    applyStimulus(S_FETCH, 1'b0, 8'h00, 1'b0, 4'h0);
    checks++; if (ram_addr !== 8'h00) begin failures++; $display("[TB] FAIL post_reset_addr got=%h exp=00", ram_addr); end
    clockEdge();
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] mPc;
    logic [3:0]        mFlags;
    logic [DATA_W-1:0] mInstr;
    logic [DATA_W-1:0] mRdata;
    logic              expValid;
    logic              expCcc;
    logic [1:0]        st;
    logic              pl, fwe;
    logic [ADDR_W-1:0] tgt;
    logic [3:0]        fin;
    rst_n = 1'b0;
    applyStimulus(S_IDLE, 1'b0, '0, 1'b0, 4'h0);
    clockEdge();
    rst_n = 1'b1;
    mPc = '0; mFlags = '0; mInstr = '0; mRdata = '0;
    for (int i = 0; i < 400; i++) begin
      st  = (i == 0) ? S_FETCH : 2'($urandom_range(0, 3));
      pl  = 1'($urandom_range(0, 1));
      tgt = ADDR_W'($urandom);
      fwe = 1'($urandom_range(0, 1));
      fin = 4'($urandom);
      applyStimulus(st, pl, tgt, fwe, fin);
      expCcc = (st == S_LOAD) ? condModel(mRdata[DATA_W-1 -: 4], mFlags) : 1'b0;
      checks++; if (ram_en !== (st == S_FETCH)) begin failures++; $display("[TB] FAIL rnd_ram_en i=%0d got=%b exp=%b", i, ram_en, st == S_FETCH); end
      checks++; if (condition_code_check !== expCcc) begin failures++; $display("[TB] FAIL rnd_ccc i=%0d got=%b exp=%b", i, condition_code_check, expCcc); end
      if (st == S_FETCH) begin
        checks++; if (ram_addr !== mPc) begin failures++; $display("[TB] FAIL rnd_addr i=%0d got=%h exp=%h", i, ram_addr, mPc); end
      end
      expValid = (st == S_LOAD);
      if (st == S_FETCH) begin
        mRdata = mem[mPc];
        mPc = mPc + 1'b1;
      end
      if (st == S_LOAD) mInstr = mRdata;
      if (st == S_ALU && pl) mPc = tgt;
      if (st == S_ALU && fwe && CondEn) mFlags = fin;
      clockEdge();
      checks++; if (pc !== mPc) begin failures++; $display("[TB] FAIL rnd_pc i=%0d got=%h exp=%h", i, pc, mPc); end
      checks++; if (instr !== mInstr) begin failures++; $display("[TB] FAIL rnd_instr i=%0d got=%h exp=%h", i, instr, mInstr); end
      checks++; if (instr_valid !== expValid) begin failures++; $display("[TB] FAIL rnd_valid i=%0d got=%b exp=%b", i, instr_valid, expValid); end
      checks++; if (flags !== mFlags) begin failures++; $display("[TB] FAIL rnd_flags i=%0d got=%h exp=%h", i, flags, mFlags); end
    end
  endtask

  // Run all scenarios in sequence, then report
  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = $urandom;
    rst_n = 1'b0;
    curr_state = S_IDLE;
    pc_load = 1'b0;
    pc_target = '0;
    flags_we = 1'b0;
    flags_in = 4'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_two_fetches();
    test_flags();
    test_branch();
    test_nv();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
